// File: rtl/serial_ones_tracker.sv
// Serial ones tracker: counts accepted bits and ones per fixed-length frame,
// flags frame completion and whether the frame's ones count matched modulo MOD.
module serial_ones_tracker #(
    parameter  int FRAME_LEN = 8,
    parameter  int MOD       = 2,
    localparam int CW        = $clog2(FRAME_LEN + 1),
    localparam int MW        = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    input  logic          start,
    input  logic          odd_mode,
    output logic          out,
    output logic [CW-1:0] ones_cnt,
    output logic [CW-1:0] bit_cnt,
    output logic          busy,
    output logic          frame_valid,
    output logic          frame_match
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);
    localparam logic [MW-1:0] MOD_LAST = MW'(MOD - 1);

    state_t          state, state_d;
    logic            clear, accept;
    logic [MW-1:0]   mod_cnt;

    function automatic logic [MW-1:0] mod_advance(input logic [MW-1:0] m, input logic b);
        if (!b)
            return m;
        return (m == MOD_LAST) ? '0 : m + MW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // A start in RUN restarts the frame and takes priority over any valid bit.
    always_comb begin
        state_d = state;
        clear   = 1'b0;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    clear = 1'b1;
                end else if (din_valid) begin
                    accept = 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            ones_cnt    <= '0;
            mod_cnt     <= '0;
            frame_match <= 1'b0;
        end else begin
            if (clear) begin
                bit_cnt  <= '0;
                ones_cnt <= '0;
                mod_cnt  <= '0;
            end else if (accept) begin
                bit_cnt  <= bit_cnt + CW'(1);
                ones_cnt <= ones_cnt + CW'(din);
                mod_cnt  <= mod_advance(mod_cnt, din);
            end
            // Match is captured on the edge leaving DONE, before any restart clears mod_cnt.
            if (state == DONE)
                frame_match <= odd_mode ? (mod_cnt != '0) : (mod_cnt == '0);
        end
    end

    assign out         = (mod_cnt == '0);
    assign busy        = (state == RUN);
    assign frame_valid = (state == DONE);

endmodule
